// File: rtl/lcd_blit_ctrl.sv
// Blits AHB-resident images into an LCD write FIFO, one row window per line.
// Define LCD_BLIT_HRESP_EN to abort an image on an AHB error response (adds err).
module lcd_blit_ctrl #(
  parameter int unsigned COORD_W   = 9,
  parameter logic [7:0]  X_CMD     = 8'h2A,
  parameter logic [7:0]  Y_CMD     = 8'h2B,
  parameter logic [7:0]  RAMWR_CMD = 8'h2C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cmd_rdata,
  input  logic        rempty,
  output logic        rinc,
  input  logic        wfull,
  output logic        winc,
  output logic [15:0] wdata,
  output logic        ID,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic        init_end,
  output logic        init_mode,
  output logic        busy,
  output logic        done
`ifdef LCD_BLIT_HRESP_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [3:0] {
    IDLE, SIZE, ADDR,
    XCMD, XHI, XLO,
    YCMD, YHI, YLO,
    RAMWR, PADDR, PDATA,
    INIT
  } state_t;

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  state_t state, state_n;

  logic [COORD_W-1:0] x0, y0;
  logic [COORD_W-1:0] wid, hgt;
  logic [COORD_W-1:0] row, col;
  logic [31:0]        addr;

  logic [COORD_W-1:0] yr;
  logic [15:0]        x16, y16;
  logic               last_col, last_row;
  logic               pix_ok;

  assign HSIZE    = 3'b001;
  assign yr       = y0 + row;
  assign x16      = 16'(x0);
  assign y16      = 16'(yr);
  assign last_col = (col == wid - ONE);
  assign last_row = (row == hgt - ONE);

`ifdef LCD_BLIT_HRESP_EN
  logic err_hit;
`else
  logic unused_hresp;
  assign unused_hresp = HRESP;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x0   <= '0;
      y0   <= '0;
      wid  <= '0;
      hgt  <= '0;
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else begin
      if (state == IDLE && rinc) begin
        x0 <= cmd_rdata[COORD_W-1:0];
        y0 <= cmd_rdata[16 +: COORD_W];
      end
      if (state == SIZE && rinc) begin
        wid <= cmd_rdata[COORD_W-1:0];
        hgt <= cmd_rdata[16 +: COORD_W];
      end
      if (state == ADDR && rinc) begin
        addr <= cmd_rdata;
        row  <= '0;
        col  <= '0;
      end
      if (pix_ok) begin
        addr <= addr + 32'd2;
        if (last_col) begin
          col <= '0;
          row <= row + ONE;
        end else begin
          col <= col + ONE;
        end
      end
    end
  end

`ifdef LCD_BLIT_HRESP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (err_hit) begin
      err <= 1'b1;
    end else if (state == IDLE && rinc) begin
      err <= 1'b0;
    end
  end
`endif

  always_comb begin
    state_n   = state;
    rinc      = 1'b0;
    winc      = 1'b0;
    wdata     = '0;
    ID        = 1'b0;
    HTRANS    = 2'b00;
    HADDR     = '0;
    done      = 1'b0;
    pix_ok    = 1'b0;
    busy      = (state != IDLE);
    init_mode = (state == INIT);
`ifdef LCD_BLIT_HRESP_EN
    err_hit   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!rempty) begin
          rinc    = 1'b1;
          state_n = cmd_rdata[31] ? INIT : SIZE;
        end
      end
      SIZE: begin
        if (!rempty) begin
          rinc    = 1'b1;
          state_n = ADDR;
        end
      end
      ADDR: begin
        if (!rempty) begin
          rinc = 1'b1;
          if (wid == '0 || hgt == '0) begin
            done    = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = XCMD;
          end
        end
      end
      XCMD: begin
        if (!wfull) begin
          winc    = 1'b1;
          wdata   = {8'h00, X_CMD};
          state_n = XHI;
        end
      end
      XHI: begin
        if (!wfull) begin
          winc    = 1'b1;
          ID      = 1'b1;
          wdata   = {8'h00, x16[15:8]};
          state_n = XLO;
        end
      end
      XLO: begin
        if (!wfull) begin
          winc    = 1'b1;
          ID      = 1'b1;
          wdata   = {8'h00, x16[7:0]};
          state_n = YCMD;
        end
      end
      YCMD: begin
        if (!wfull) begin
          winc    = 1'b1;
          wdata   = {8'h00, Y_CMD};
          state_n = YHI;
        end
      end
      YHI: begin
        if (!wfull) begin
          winc    = 1'b1;
          ID      = 1'b1;
          wdata   = {8'h00, y16[15:8]};
          state_n = YLO;
        end
      end
      YLO: begin
        if (!wfull) begin
          winc    = 1'b1;
          ID      = 1'b1;
          wdata   = {8'h00, y16[7:0]};
          state_n = RAMWR;
        end
      end
      RAMWR: begin
        if (!wfull) begin
          winc    = 1'b1;
          wdata   = {8'h00, RAMWR_CMD};
          state_n = PADDR;
        end
      end
      // FIFO room is reserved here so the data phase can push blindly
      PADDR: begin
        if (!wfull) begin
          HTRANS = 2'b10;
          HADDR  = addr;
          if (HREADY) begin
            state_n = PDATA;
          end
        end
      end
      PDATA: begin
        if (HREADY) begin
`ifdef LCD_BLIT_HRESP_EN
          if (HRESP) begin
            err_hit = 1'b1;
            done    = 1'b1;
            state_n = IDLE;
          end else
`endif
          begin
            winc   = 1'b1;
            ID     = 1'b1;
            wdata  = addr[1] ? HRDATA[31:16] : HRDATA[15:0];
            pix_ok = 1'b1;
            if (!last_col) begin
              state_n = PADDR;
            end else if (last_row) begin
              done    = 1'b1;
              state_n = IDLE;
            end else begin
              state_n = XCMD;
            end
          end
        end
      end
      INIT: begin
        if (init_end) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!rst_n) begin
      rinc      = 1'b0;
      winc      = 1'b0;
      wdata     = '0;
      ID        = 1'b0;
      HTRANS    = 2'b00;
      HADDR     = '0;
      done      = 1'b0;
      busy      = 1'b0;
      init_mode = 1'b0;
      pix_ok    = 1'b0;
`ifdef LCD_BLIT_HRESP_EN
      err_hit   = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_blit_ctrl.sv
// Bench for lcd_blit_ctrl: FIFO and AHB memory models around the DUT,
// expected LCD stream built from the image description.
module tb_lcd_blit_ctrl;
  localparam int CW = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cmd_rdata;
  logic        rempty;
  logic        rinc;
  logic        wfull;
  logic        winc;
  logic [15:0] wdata;
  logic        ID;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        init_end;
  logic        init_mode;
  logic        busy;
  logic        done;
`ifdef LCD_BLIT_HRESP_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  lcd_blit_ctrl #(
    .COORD_W(CW), .X_CMD(8'h2A), .Y_CMD(8'h2B), .RAMWR_CMD(8'h2C)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_rdata(cmd_rdata), .rempty(rempty), .rinc(rinc),
    .wfull(wfull), .winc(winc), .wdata(wdata), .ID(ID),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .init_end(init_end), .init_mode(init_mode),
    .busy(busy), .done(done)
`ifdef LCD_BLIT_HRESP_EN
    , .err(err)
`endif
  );

  logic [31:0] cmdq[$];
  logic [16:0] outq[$];
  logic [16:0] expq[$];
  logic [31:0] ahbq[$];
  logic [31:0] expa[$];

  int total = 0;
  int bad = 0;
  int pops = 0;
  int dones = 0;
  int trans = 0;
  int both = 0;
  logic [31:0] data_addr = '0;
  logic [15:0] salt = '0;
  bit rnd = 0;
  bit wf_force = 0;
  bit hr_low = 0;

  function automatic logic [15:0] pix(input logic [31:0] a);
    return (a[15:0] * 16'd40503) ^ a[31:16] ^ salt;
  endfunction

  function automatic logic [31:0] pack(input int hi, input int lo);
    return (32'(hi) << 16) | 32'(lo);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd();
    rempty = (cmdq.size() == 0);
    cmd_rdata = rempty ? $urandom : cmdq[0];
  endtask

  task automatic tick();
    logic pop;
    @(negedge clk);
    pop = rinc;
    if (rinc && winc) both++;
    if (rinc) pops++;
    if (winc) outq.push_back({ID, wdata});
    if (done) dones++;
    if (HTRANS == 2'b10) begin
      trans++;
      if (HREADY) begin
        ahbq.push_back(HADDR);
        data_addr = HADDR;
      end
    end
    @(posedge clk);
    #1;
    if (pop && cmdq.size() > 0) cmdq.delete(0);
    wfull  = wf_force || (rnd && $urandom_range(0, 3) == 0);
    HREADY = !hr_low && (!rnd || $urandom_range(0, 3) != 0);
    HRDATA = {pix((data_addr & ~32'h3) | 32'h2), pix(data_addr & ~32'h3)};
    drive_cmd();
  endtask

  task automatic start_image(input int x0, input int y0, input int w,
                             input int h, input logic [31:0] base);
    logic [31:0] a;
    int yr;
    outq.delete();
    ahbq.delete();
    expq.delete();
    expa.delete();
    dones = 0;
    pops = 0;
    trans = 0;
    salt = 16'($urandom);
    a = base;
    for (int r = 0; r < h && w > 0; r++) begin
      yr = (y0 + r) % (1 << CW);
      expq.push_back({1'b0, 16'h002A});
      expq.push_back({1'b1, 16'(x0 / 256)});
      expq.push_back({1'b1, 16'(x0 % 256)});
      expq.push_back({1'b0, 16'h002B});
      expq.push_back({1'b1, 16'(yr / 256)});
      expq.push_back({1'b1, 16'(yr % 256)});
      expq.push_back({1'b0, 16'h002C});
      for (int c = 0; c < w; c++) begin
        expa.push_back(a);
        expq.push_back({1'b1, pix(a)});
        a = a + 32'd2;
      end
    end
    cmdq.push_back(pack(y0, x0));
    cmdq.push_back(pack(h, w));
    cmdq.push_back(base);
    drive_cmd();
  endtask

  task automatic finish_image(input string tag);
    int n = 0;
    while (dones == 0 && n < 4000) begin
      tick();
      n++;
    end
    check({tag, " in_time"}, 64'(n < 4000), 1);
    tick();
    check({tag, " pushes"}, outq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < outq.size(); i++)
      check($sformatf("%s push%0d", tag, i), outq[i], expq[i]);
    check({tag, " reads"}, ahbq.size(), expa.size());
    for (int i = 0; i < expa.size() && i < ahbq.size(); i++)
      check($sformatf("%s addr%0d", tag, i), ahbq[i], expa[i]);
    check({tag, " done"}, dones, 1);
    check({tag, " pops"}, pops, 3);
    check({tag, " idle"}, busy, 0);
  endtask

  task automatic reset_outs(input string tag);
    check({tag, " rinc"}, rinc, 0);
    check({tag, " winc"}, winc, 0);
    check({tag, " wdata"}, wdata, 0);
    check({tag, " ID"}, ID, 0);
    check({tag, " HTRANS"}, HTRANS, 0);
    check({tag, " HADDR"}, HADDR, 0);
    check({tag, " init_mode"}, init_mode, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
  endtask

  initial begin
    int n;
    int sz;
    int t0;
    rst_n = 1'b0;
    wfull = 1'b0;
    HREADY = 1'b1;
    HRDATA = '0;
    HRESP = 1'b0;
    init_end = 1'b0;
    drive_cmd();

    start_image(3, 5, 2, 2, 32'h100);
    tick();
    tick();
    reset_outs("reset");
    check("hsize", HSIZE, 3'b001);
    rst_n = 1'b1;
    finish_image("basic");

    cmdq.push_back(32'h8000_0000);
    drive_cmd();
    pops = 0;
    outq.delete();
    trans = 0;
    n = 0;
    while (pops == 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("init mode", init_mode, 1);
    check("init busy", busy, 1);
    init_end = 1'b1;
    tick();
    init_end = 1'b0;
    check("init exit", init_mode, 0);
    check("init idle", busy, 0);
    check("init pops", pops, 1);
    check("init pushes", outq.size(), 0);
    check("init trans", trans, 0);

    start_image(7, 9, 0, 4, 32'h200);
    finish_image("zero");
    check("zero trans", trans, 0);

    start_image(300, 260, 3, 1, 32'h4000_0010);
    n = 0;
    while (!(outq.size() > 0 && outq[$] == {1'b0, 16'h002B}) && n < 100) begin
      tick();
      n++;
    end
    wf_force = 1;
    wfull = 1'b1;
    sz = outq.size();
    t0 = trans;
    repeat (5) tick();
    check("yhi hold push", outq.size(), sz);
    check("yhi hold trans", trans, t0);
    wf_force = 0;
    wfull = 1'b0;
    n = 0;
    while (!(outq.size() > 0 && outq[$] == {1'b0, 16'h002C}) && n < 100) begin
      tick();
      n++;
    end
    wf_force = 1;
    wfull = 1'b1;
    sz = outq.size();
    t0 = trans;
    repeat (5) tick();
    check("paddr hold push", outq.size(), sz);
    check("paddr hold trans", trans, t0);
    wf_force = 0;
    wfull = 1'b0;
    finish_image("wfull");

    start_image(1, 2, 2, 1, 32'hFFFF_FFFE);
    n = 0;
    while (ahbq.size() == 0 && n < 100) begin
      tick();
      n++;
    end
    hr_low = 1;
    HREADY = 1'b0;
    repeat (3) tick();
    check("wait no pixel", outq.size(), 7);
    hr_low = 0;
    HREADY = 1'b1;
    finish_image("wrap");

    rnd = 1;
    start_image(100, 510, 3, 3, 32'h0000_8000);
    n = 0;
    while (ahbq.size() < 2 && n < 400) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    tick();
    reset_outs("midreset");
    rst_n = 1'b1;
    tick();
    check("post reset idle", busy, 0);
    check("post reset cmds", cmdq.size(), 0);
    start_image(511, 508, 2, 4, 32'h1234_5678);
    finish_image("after reset");

    for (int k = 0; k < 6; k++) begin
      start_image($urandom_range(0, 511),
                  (k % 2 == 0) ? $urandom_range(505, 511) : $urandom_range(0, 511),
                  $urandom_range(1, 4), $urandom_range(1, 4),
                  $urandom & ~32'h1);
      finish_image($sformatf("rand%0d", k));
    end

    check("rinc winc overlap", both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
